// File: rtl/common_pkg.sv
// Shared types and sizing for the systolic-array feeder blocks.
package common_pkg;

  localparam int DATA_W         = 16;
  localparam int SYS_ARRAY_SIZE = 4;
  localparam int ROW_CNT_W      = 8;

  typedef logic signed [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_FLUSH = 2'd2
  } feed_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// Reset-clearable {valid,data} shift register; one instance per array lane.
module skew_delay_line
  import common_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_vld,
  input  data_t i_data,
  output logic  o_vld,
  output data_t o_data
);

  logic [DEPTH-1:0] r_vld_p;
  data_t            r_data_p [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld_p <= '0;
      for (int k = 0; k < DEPTH; k++) r_data_p[k] <= '0;
    end else begin
      r_vld_p[0]  <= i_vld;
      r_data_p[0] <= i_data;
      for (int k = 1; k < DEPTH; k++) begin
        r_vld_p[k]  <= r_vld_p[k-1];
        r_data_p[k] <= r_data_p[k-1];
      end
    end
  end

  assign o_vld  = r_vld_p[DEPTH-1];
  assign o_data = r_data_p[DEPTH-1];

endmodule

// File: rtl/skew_feeder.sv
// Accepts full matrix rows and skews them diagonally onto the systolic-array
// edge: lane i sees a row i+1 cycles after it is accepted.
module skew_feeder
  import common_pkg::*;
#(
  parameter int SIZE = SYS_ARRAY_SIZE
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 START_I,
  input  logic [ROW_CNT_W-1:0] ROWS_I,
  input  logic                 ROW_VALID_I,
  output logic                 ROW_READY_O,
  input  data_t [SIZE-1:0]     ROW_DATA_I,
  output data_t [SIZE-1:0]     ARRAY_DATA_O,
  output logic  [SIZE-1:0]     ARRAY_VALID_O,
  output logic                 BUSY_O,
  output logic                 DONE_O
);

  localparam int                  FLUSH_W    = $clog2(SIZE + 1);
  localparam logic [FLUSH_W-1:0]  FLUSH_LAST = FLUSH_W'(SIZE - 1);

  feed_state_t          r_state;
  feed_state_t          w_state_nxt;
  logic [ROW_CNT_W-1:0] r_rows_rem;
  logic [FLUSH_W-1:0]   r_flush_cnt;
  logic                 r_done;
  logic                 w_accept;
  logic                 w_start_job;
  logic                 w_start_empty;
  logic                 w_flush_end;
  data_t [SIZE-1:0]     w_lane_data;

  assign w_accept      = ROW_VALID_I && (r_state == ST_FEED);
  assign w_start_job   = (r_state == ST_IDLE) && START_I && (ROWS_I != '0);
  assign w_start_empty = (r_state == ST_IDLE) && START_I && (ROWS_I == '0);
  assign w_flush_end   = (r_state == ST_FLUSH) && (r_flush_cnt == FLUSH_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_job) w_state_nxt = ST_FEED;
      ST_FEED:  if (w_accept && (r_rows_rem == ROW_CNT_W'(1))) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (w_flush_end) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_rows_rem  <= '0;
      r_flush_cnt <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_start_empty || w_flush_end;
      if (w_start_job)   r_rows_rem <= ROWS_I;
      else if (w_accept) r_rows_rem <= r_rows_rem - ROW_CNT_W'(1);
      // Flush counter only runs in FLUSH and rests at zero otherwise.
      if ((r_state == ST_FLUSH) && !w_flush_end) r_flush_cnt <= r_flush_cnt + FLUSH_W'(1);
      else                                       r_flush_cnt <= '0;
    end
  end

  assign ROW_READY_O = (r_state == ST_FEED);
  assign BUSY_O      = (r_state == ST_FEED) || (r_state == ST_FLUSH);
  assign DONE_O      = r_done;

  // Non-accepted cycles enter the lanes as zero-data bubbles.
  genvar gi;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_lane
      assign w_lane_data[gi] = w_accept ? ROW_DATA_I[gi] : data_t'(0);

      skew_delay_line #(
        .DEPTH (gi + 1)
      ) u_dly (
        .i_clk  (CLK),
        .i_rst  (RESET),
        .i_vld  (w_accept),
        .i_data (w_lane_data[gi]),
        .o_vld  (ARRAY_VALID_O[gi]),
        .o_data (ARRAY_DATA_O[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_skew_feeder.sv
// Directed scoreboard bench for skew_feeder (SIZE=4).
module tb_skew_feeder;
  import common_pkg::*;

  localparam int SIZE = 4;
  typedef data_t [SIZE-1:0] row_t;
  typedef struct {int lane; int cyc; data_t d;} lane_exp_t;

  logic                 CLK;
  logic                 RESET;
  logic                 START_I;
  logic [ROW_CNT_W-1:0] ROWS_I;
  logic                 ROW_VALID_I;
  logic                 ROW_READY_O;
  row_t                 ROW_DATA_I;
  row_t                 ARRAY_DATA_O;
  logic [SIZE-1:0]      ARRAY_VALID_O;
  logic                 BUSY_O;
  logic                 DONE_O;

  lane_exp_t lane_q[$];
  int        done_q[$];
  int        cyc    = 0;
  int        n_vec  = 0;
  int        n_miss = 0;
  bit        mon_en = 0;
  int        m_idx;
  bit        m_zero_ok;

  skew_feeder #(.SIZE(SIZE)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .START_I       (START_I),
    .ROWS_I        (ROWS_I),
    .ROW_VALID_I   (ROW_VALID_I),
    .ROW_READY_O   (ROW_READY_O),
    .ROW_DATA_I    (ROW_DATA_I),
    .ARRAY_DATA_O  (ARRAY_DATA_O),
    .ARRAY_VALID_O (ARRAY_VALID_O),
    .BUSY_O        (BUSY_O),
    .DONE_O        (DONE_O)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic row_t mk_row(input int a, input int b, input int c, input int d);
    row_t r;
    r[0] = data_t'(a);
    r[1] = data_t'(b);
    r[2] = data_t'(c);
    r[3] = data_t'(d);
    return r;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_row(input row_t r, input int nlanes);
    for (int i = 0; i < nlanes; i++) lane_q.push_back('{i, cyc + 1 + i, r[i]});
  endtask

  task automatic drive(input bit v, input row_t r, input bit exp_rdy);
    ROW_VALID_I = v;
    ROW_DATA_I  = r;
    check("row_ready", ROW_READY_O, exp_rdy);
    if (v && exp_rdy) push_row(r, SIZE);
    step();
  endtask

  task automatic start(input int rows);
    START_I = 1'b1;
    ROWS_I  = ROW_CNT_W'(rows);
    step();
    START_I = 1'b0;
    ROWS_I  = '0;
  endtask

  task automatic wait_idle();
    int k = 0;
    ROW_VALID_I = 1'b0;
    ROW_DATA_I  = '0;
    while (BUSY_O !== 1'b0 && k < 50) begin
      step();
      k++;
    end
    check("idle_timeout", (k < 50), 1);
    step();
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},  ARRAY_DATA_O,  0);
    check({tag, "_valid"}, ARRAY_VALID_O, 0);
    check({tag, "_ready"}, ROW_READY_O,   0);
    check({tag, "_busy"},  BUSY_O,        0);
    check({tag, "_done"},  DONE_O,        0);
  endtask

  // Monitor: matches every lane valid and DONE pulse against the scoreboard.
  always @(negedge CLK) begin
    if (mon_en) begin
      m_zero_ok = 1'b1;
      for (int i = 0; i < SIZE; i++) begin
        if (ARRAY_VALID_O[i]) begin
          m_idx = -1;
          for (int j = 0; j < lane_q.size(); j++)
            if (m_idx < 0 && lane_q[j].lane == i) m_idx = j;
          if (m_idx < 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL lane_unexpected lane=%0d cyc=%0d got valid data=%0d want no valid", i, cyc, ARRAY_DATA_O[i]);
          end else begin
            check($sformatf("lane%0d_data", i), ARRAY_DATA_O[i], lane_q[m_idx].d);
            check($sformatf("lane%0d_cycle", i), cyc, lane_q[m_idx].cyc);
            lane_q.delete(m_idx);
          end
        end else if (ARRAY_DATA_O[i] != '0) begin
          m_zero_ok = 1'b0;
        end
      end
      check("invalid_lane_zero", m_zero_ok, 1);
      m_idx = 0;
      while (m_idx < lane_q.size()) begin
        if (lane_q[m_idx].cyc < cyc) begin
          n_vec++;
          n_miss++;
          $display("FAIL lane_missing lane=%0d got no valid by cyc=%0d want data=%0d at cyc=%0d",
                   lane_q[m_idx].lane, cyc, lane_q[m_idx].d, lane_q[m_idx].cyc);
          lane_q.delete(m_idx);
        end else begin
          m_idx++;
        end
      end
      if (DONE_O === 1'b1) begin
        if (done_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL done_unexpected cyc=%0d got pulse want none", cyc);
        end else begin
          check("done_cycle", cyc, done_q.pop_front());
        end
      end
      if (done_q.size() != 0 && done_q[0] < cyc) begin
        n_vec++;
        n_miss++;
        $display("FAIL done_missing cyc=%0d got no pulse want pulse at cyc=%0d", cyc, done_q[0]);
        void'(done_q.pop_front());
      end
    end
  end

  initial begin
    RESET       = 1'b1;
    START_I     = 1'b0;
    ROWS_I      = '0;
    ROW_VALID_I = 1'b0;
    ROW_DATA_I  = '0;
    step();
    mon_en = 1'b1;
    step();
    step();
    check_all_zero("reset");
    RESET = 1'b0;
    step();
    check_all_zero("post_reset");

    // Single row: lanes at +1..+4, DONE at +5.
    start(1);
    check("t1_busy", BUSY_O, 1);
    done_q.push_back(cyc + 5);
    drive(1'b1, mk_row(1, 2, 3, 4), 1'b1);
    check("t1_busy_flush", BUSY_O, 1);
    wait_idle();

    // Three rows with ROW_VALID_I held high; ready drops at relative cycle 3, DONE at 7.
    start(3);
    done_q.push_back(cyc + 7);
    drive(1'b1, mk_row(10, 11, 12, 13), 1'b1);
    drive(1'b1, mk_row(20, 21, 22, 23), 1'b1);
    drive(1'b1, mk_row(30, 31, 32, 33), 1'b1);
    drive(1'b1, mk_row(99, 99, 99, 99), 1'b0);
    drive(1'b1, mk_row(98, 98, 98, 98), 1'b0);
    drive(1'b1, mk_row(97, 97, 97, 97), 1'b0);
    wait_idle();

    // Row A, one bubble carrying junk data, row B.
    start(2);
    done_q.push_back(cyc + 2 + 5);
    drive(1'b1, mk_row(-1, 100, -32768, 32767), 1'b1);
    drive(1'b0, mk_row(55, 55, 55, 55), 1'b1);
    drive(1'b1, mk_row(5, 6, 7, 8), 1'b1);
    drive(1'b0, mk_row(0, 0, 0, 0), 1'b0);
    wait_idle();

    // Zero-row job: DONE next cycle, nothing else moves.
    START_I = 1'b1;
    ROWS_I  = '0;
    done_q.push_back(cyc + 1);
    step();
    START_I = 1'b0;
    check("t4_busy", BUSY_O, 0);
    check("t4_ready", ROW_READY_O, 0);
    step();
    check("t4_busy_after", BUSY_O, 0);
    step();

    // Reset during FLUSH: only lanes 0 and 1 get out, then no DONE.
    start(1);
    ROW_VALID_I = 1'b1;
    ROW_DATA_I  = mk_row(41, 42, 43, 44);
    check("t5_ready", ROW_READY_O, 1);
    push_row(ROW_DATA_I, 2);
    step();
    ROW_VALID_I = 1'b0;
    ROW_DATA_I  = '0;
    check("t5_busy_flush", BUSY_O, 1);
    step();
    RESET = 1'b1;
    step();
    check_all_zero("t5_after_reset");
    RESET = 1'b0;
    repeat (8) step();
    check_all_zero("t5_idle");

    // START during FEED with another count is ignored; two rows complete.
    start(2);
    done_q.push_back(cyc + 1 + 5);
    START_I = 1'b1;
    ROWS_I  = ROW_CNT_W'(5);
    drive(1'b1, mk_row(61, 62, 63, 64), 1'b1);
    START_I = 1'b0;
    ROWS_I  = '0;
    drive(1'b1, mk_row(71, 72, 73, 74), 1'b1);
    drive(1'b1, mk_row(81, 82, 83, 84), 1'b0);
    wait_idle();
    check("t6_busy_end", BUSY_O, 0);

    repeat (6) step();
    check("lane_q_empty", lane_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/skew_feeder.md
SKEW_FEEDER -- requirements
Module: skew_feeder

Interface
REQ-001 Parameter SIZE SHALL default to SYS_ARRAY_SIZE and set the number of systolic-array input lanes.
REQ-002 Port CLK  in  1  sole clock; all state updates on its rising edge.
REQ-003 Port RESET  in  1  reset, synchronous and active-high.
REQ-004 Port START_I  in  1  one-cycle request to begin feeding one matrix.
REQ-005 Port ROWS_I  in  ROW_CNT_W  number of rows in the matrix; sampled with START_I.
REQ-006 Port ROW_VALID_I  in  1  ROW_DATA_I holds a valid full matrix row.
REQ-007 Port ROW_READY_O  out  1  block accepts a row this cycle.
REQ-008 Port ROW_DATA_I  in  data_t[SIZE-1:0]  full matrix row; element i targets lane i.
REQ-009 Port ARRAY_DATA_O  out  data_t[SIZE-1:0]  skewed lane data to the array edge.
REQ-010 Port ARRAY_VALID_O  out  [SIZE-1:0]  per-lane valid for ARRAY_DATA_O.
REQ-011 Port BUSY_O  out  1  high while state is FEED or FLUSH.
REQ-012 Port DONE_O  out  1  one-cycle pulse when the matrix has fully left the block.

Function
REQ-013 FSM SHALL have states IDLE, FEED and FLUSH.
REQ-014 In IDLE, START_I=1 with ROWS_I!=0 SHALL latch ROWS_I into a remaining-row counter and enter FEED next cycle.
REQ-015 In IDLE, START_I=1 with ROWS_I=0 SHALL stay in IDLE and pulse DONE_O in the next cycle.
REQ-016 START_I outside IDLE SHALL be ignored.
REQ-017 ROW_READY_O SHALL be 1 exactly when the state is FEED; a row is accepted when ROW_VALID_I and ROW_READY_O are both 1.
REQ-018 A row accepted in cycle t SHALL present element i on ARRAY_DATA_O[i] with ARRAY_VALID_O[i]=1 in cycle t+1+i only.
REQ-019 Any FEED or FLUSH cycle with no accepted row SHALL inject a bubble: data 0, valid 0, skewed exactly like a row.
REQ-020 Each accepted row SHALL decrement the remaining-row counter by 1; acceptance of the final row SHALL enter FLUSH next cycle.
REQ-021 FLUSH SHALL last exactly SIZE cycles, counted by a flush counter, then return to IDLE with DONE_O=1 for that one cycle.
REQ-022 For a final row accepted in cycle t, DONE_O SHALL pulse in cycle t+SIZE+1, one cycle after lane SIZE-1 shows that row.
REQ-023 Lanes with ARRAY_VALID_O[i]=0 SHALL drive ARRAY_DATA_O[i]=0.
REQ-024 ROW_DATA_I SHALL be ignored when no row is accepted.

Reset
REQ-025 RESET=1 SHALL set state IDLE and clear both counters and all delay-line stages.
REQ-026 During and after reset, outputs SHALL be ARRAY_DATA_O=0, ARRAY_VALID_O=0, ROW_READY_O=0, BUSY_O=0 and DONE_O=0.
REQ-027 RESET mid-operation SHALL discard in-flight rows with no DONE_O pulse.

Structure
REQ-028 data_t, SYS_ARRAY_SIZE, ROW_CNT_W and the FSM state enum feed_state_t SHALL live in common_pkg.
REQ-029 The block SHALL instantiate one sub-module, skew_delay_line, per lane i. Each instance is a reset-clearable shift register of {valid,data} with depth i+1.
REQ-030 ARRAY_DATA_O and ARRAY_VALID_O SHALL be register outputs.

Verification
REQ-031 SIZE=4, ROWS_I=1, row [1,2,3,4] accepted at cycle 0 -> the following SHALL be observed:
- lane0=1 at cycle 1;
- lane1=2 at cycle 2;
- lane2=3 at cycle 3;
- lane3=4 at cycle 4;
- DONE_O at cycle 5;
- all other valids 0.
REQ-032 SIZE=4, ROWS_I=3, ROW_VALID_I continuously high from cycle 0 -> the following SHALL be observed:
- lane0 valid at cycles 1-3;
- lane3 valid at cycles 4-6;
- ROW_READY_O low from cycle 3;
- DONE_O at cycle 7.
REQ-033 ROWS_I=2, row A at cycle 0, ROW_VALID_I low at cycle 1, row B at cycle 2 -> every lane SHALL show A, one zero/invalid bubble, then B.
REQ-034 START_I with ROWS_I=0 -> DONE_O SHALL pulse the next cycle, with BUSY_O, ROW_READY_O and all ARRAY_VALID_O staying 0.
REQ-035 RESET pulsed during FLUSH with valid lanes in flight -> the following SHALL hold:
- next cycle all outputs are 0 and state is IDLE;
- DONE_O never pulses.
REQ-036 START_I during FEED with a different ROWS_I -> it SHALL be ignored and the original row count SHALL complete unchanged.
